// File: rtl/hex_sum_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_sum_scheduler_if
// Description : Client-side bus of the shared hex-digit-sum scheduler.
//               Carries the request/operand vectors toward the scheduler and
//               the grant, status and result signals back to the clients.
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_sum_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]    req;
   logic [32*N_REQ-1:0] num_flat;
   logic [N_REQ-1:0]    gnt;
   logic                busy;
   logic                done;
   logic [IDW-1:0]      done_id;
   logic [6:0]          sum;

   modport master (
      output req, num_flat,
      input  gnt, busy, done, done_id, sum
   );

   modport slave (
      input  req, num_flat,
      output gnt, busy, done, done_id, sum
   );
endinterface
`default_nettype wire

// File: rtl/hex_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hex_sum_scheduler
// Description : Round-robin scheduler sharing one serial hex-digit-sum engine
//               among N_REQ clients. Grants one requester, captures its 32-bit
//               operand, accumulates its eight nibbles (LSB first) over eight
//               cycles and returns the 7-bit sum tagged with the client index.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_sum_scheduler #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  wire                 clk,
   input  wire                 rst,
   hex_sum_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_LAST_STEP = 4'd7;

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [31:0]      r_shift;
   logic [6:0]       r_acc;
   logic [3:0]       r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic             r_busy;
   logic             r_done;
   logic [IDW-1:0]   r_done_id;
   logic [6:0]       r_sum;

   logic             w_any;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_cand;
   logic [31:0]      w_operand;
   logic [6:0]       w_acc_next;

   // Round-robin pick: scan from lowest to highest priority so the
   // highest-priority pending client (pointer+1, wrapping) is written last.
   always_comb begin
      w_any  = 1'b0;
      w_win  = r_ptr;
      w_cand = r_ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         w_cand = IDW'((int'(r_ptr) + k) % N_REQ);
         if (bus.req[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
   end

   assign w_operand  = bus.num_flat[{w_win, 5'd0} +: 32];
   assign w_acc_next = r_acc + {3'b000, r_shift[3:0]};

   // Scheduler FSM with the nibble-accumulate datapath; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= IDW'(N_REQ - 1);
         r_id      <= '0;
         r_shift   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_sum     <= '0;
      end else begin
         r_gnt  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state        <= S_RUN;
                  r_ptr          <= w_win;
                  r_id           <= w_win;
                  r_shift        <= w_operand;
                  r_acc          <= '0;
                  r_cnt          <= '0;
                  r_gnt[w_win]   <= 1'b1;
                  r_busy         <= 1'b1;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_shift <= {4'h0, r_shift[31:4]};
               r_cnt   <= r_cnt + 4'd1;
               if (r_cnt == c_LAST_STEP) begin
                  r_state   <= S_DONE;
                  r_sum     <= w_acc_next;
                  r_done_id <= r_id;
                  r_done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.done_id = r_done_id;
   assign bus.sum     = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_hex_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_sum_scheduler
// Description : Self-checking bench for hex_sum_scheduler. Directed jobs push
//               their expected {id, sum} into a scoreboard queue; a monitor
//               pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_sum_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] sb[$];

   hex_sum_scheduler_if #(.N_REQ(4), .IDW(2)) bus ();

   hex_sum_scheduler #(.N_REQ(4), .IDW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter used for grant spacing measurements.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_id", int'(bus.done_id), int'(e[8:7]));
               check("sum", int'(bus.sum), int'(e[6:0]));
            end
         end
      end
   endtask

   task automatic wait_gnt(input logic [3:0] exp, output int lat, output int at);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.gnt == 4'b0 && lat < 30);
      at = cyc;
      check("gnt_vector", int'(bus.gnt), int'(exp));
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 30);
      check("busy_clears", int'(bus.busy), 0);
   endtask

   task automatic run_job(input int idx, input logic [31:0] num,
                          input logic [6:0] exp_sum, input bit change);
      int lat, at, n;
      bus.num_flat[32*idx +: 32] = num;
      bus.req[idx] = 1'b1;
      sb.push_back({2'(idx), exp_sum});
      wait_gnt(4'(1 << idx), lat, at);
      check("gnt_latency", lat, 1);
      check("busy_at_gnt", int'(bus.busy), 1);
      bus.req[idx] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (change && n == 1) bus.num_flat[32*idx +: 32] = ~num;
      end while (!bus.done && n < 30);
      check("done_latency", n, 8);
      wait_idle();
   endtask

   // Directed stimulus; the scoreboard monitor runs alongside it.
   initial begin
      int lat, at, prev, a0, a3;
      logic [3:0] exp_order [5];
      fork
         monitor();
      join_none
      bus.req      = '0;
      bus.num_flat = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_gnt", int'(bus.gnt), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_done_id", int'(bus.done_id), 0);
      check("rst_sum", int'(bus.sum), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single jobs with hand-computed digit sums.
      run_job(2, 32'hFFFF_FFFF, 7'd120, 1'b0);
      run_job(0, 32'h1234_5678, 7'd36, 1'b0);
      run_job(1, 32'h0000_0000, 7'd0, 1'b0);

      // Fresh reset so client 0 has top priority, then all clients hold req.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.num_flat = {32'hF0F0_F0F0, 32'h0000_0009, 32'h2222_2222, 32'h1111_1111};
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      sb.push_back({2'd0, 7'd8});
      sb.push_back({2'd1, 7'd16});
      sb.push_back({2'd2, 7'd9});
      sb.push_back({2'd3, 7'd60});
      sb.push_back({2'd0, 7'd8});
      bus.req = 4'b1111;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(exp_order[k], lat, at);
         if (k > 0) check("rr_spacing", at - prev, 10);
         prev = at;
      end
      bus.req = 4'b0000;
      wait_idle();

      // After a grant to client 3, client 0 beats client 3.
      run_job(3, 32'h0000_0001, 7'd1, 1'b0);
      bus.num_flat[31:0]  = 32'h0000_00A0;
      bus.num_flat[127:96] = 32'h0000_0033;
      sb.push_back({2'd0, 7'd10});
      sb.push_back({2'd3, 7'd6});
      bus.req = 4'b1001;
      wait_gnt(4'b0001, lat, a0);
      bus.req[0] = 1'b0;
      wait_gnt(4'b1000, lat, a3);
      check("loser_spacing", a3 - a0, 10);
      bus.req[3] = 1'b0;
      wait_idle();

      // Reset during the 4th RUN cycle drops the job without a done.
      bus.num_flat[95:64] = 32'hFFFF_FFFF;
      bus.req[2] = 1'b1;
      wait_gnt(4'b0100, lat, at);
      bus.req[2] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_gnt", int'(bus.gnt), 0);
      check("async_rst_done", int'(bus.done), 0);
      check("async_rst_done_id", int'(bus.done_id), 0);
      check("async_rst_sum", int'(bus.sum), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_job(1, 32'h0000_000F, 7'd15, 1'b0);

      // Operand change after capture must not affect the result.
      run_job(2, 32'h0000_0021, 7'd3, 1'b1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hex_sum_scheduler.md
# hex_sum_scheduler

Round-robin scheduler that shares one serial hex-digit-sum engine among `N_REQ` requesters. It arbitrates among pending requests and captures the winner's 32-bit operand. It then sequences the 8-cycle nibble-accumulate datapath internally and returns the 7-bit digit sum tagged with the requester index. It sits between the client blocks and the shared arithmetic resource, and replaces per-client digit-sum instances.

## Interface
- `N_REQ`, default 4: number of requesters; legal values 2..8.
- `IDW`, default 2: index width, equal to `$clog2(N_REQ)`.
- `clk`, input, 1: clock, rising-edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req`, input, `N_REQ`: level request per client; held until that client's `gnt` bit is seen.
- `num_flat`, input, `32*N_REQ`: operands; client i occupies `[32*i+31:32*i]`.
- `gnt`, output, `N_REQ`: registered one-hot pulse, one cycle; marks the cycle the operand was captured.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse; `sum` and `done_id` are valid while it is high.
- `done_id`, output, `IDW`: index of the client whose result is on `sum`.
- `sum`, output, 7: hex-digit sum; holds its value until the next `done`.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - If any `req` bit is set, the next edge grants the highest-priority requester.
  - That edge also loads its operand into a 32-bit shift register, clears the accumulator and the 4-bit counter, sets `gnt[i]` to 1 and moves to RUN.
  - If no request is pending, the FSM stays in IDLE and `gnt` is 0.
- **RUN:**
  - Each edge adds `shift[3:0]` to the accumulator, shifts the register right by 4 and increments the counter.
  - `gnt` returns to 0 after the first RUN edge.
  - On the 8th add, the FSM moves to DONE. `sum` is set to the final accumulator value, `done_id` to the granted index, and `done` to 1.
- **DONE:**
  - Lasts one cycle, then the FSM returns to IDLE and `done` returns to 0.
  - `req` is not sampled in RUN or DONE.
- **Arbitration:**
  - Round-robin with a pointer to the last granted index.
  - Priority starts at pointer+1 and wraps modulo `N_REQ`.
  - The pointer updates only on a grant.
  - After reset the pointer equals `N_REQ-1`, so client 0 has highest priority.
- **Arithmetic:**
  - The accumulator is 7 bits and is zero-extended from each 4-bit nibble.
  - The maximum result is 8×15 = 120 < 128, so overflow is impossible.
  - Digits are consumed LSB nibble first.
- **Client contract:**
  - A client deasserts `req` within 9 cycles of seeing its `gnt` bit; otherwise it is served again as a new job.
  - A client keeps its operand stable only through the grant edge.
  - An operand change after the grant does not affect the job in flight.

## Timing
- **Reset values:** `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, `sum` = 0, state = IDLE, pointer = `N_REQ-1`, accumulator, shift register and counter = 0.
- **Reset mid-job:** the job is dropped with no `done`, and all reset values apply immediately, asynchronously.
- **Cycle sequence for one job** (edge E0 samples `req` in IDLE):
  - After E0: `gnt` and `busy` are 1.
  - After E1 through E7: RUN continues.
  - After E8: `done` is 1 and `sum` is valid.
  - After E9: the FSM is in IDLE and `busy` is 0.
  - E10 is the earliest next grant.
- Throughput is one job per 10 cycles. Latency from the grant pulse to the `done` pulse is 8 cycles.
- **Simultaneous requests:** exactly one `gnt` bit is set; losers stay pending with no side effects.
- **Request arriving during RUN or DONE:** it waits and is arbitrated at the first IDLE edge.
- `busy` is registered, derived from the state register, and glitch-free.

## Test plan
- Client 2 requests alone with `num` = 0xFFFFFFFF → `gnt` = 4'b0100 one cycle after the request, then `done` 8 cycles later with `sum` = 120 and `done_id` = 2.
- Client 0 requests with `num` = 0x12345678 → `sum` = 36. Client 1 then requests with `num` = 0x00000000 → `sum` = 0 and `done_id` = 1.
- All four `req` held high continuously → grants go to 0, 1, 2, 3, 0, with `gnt` pulses exactly 10 cycles apart and `done_id` matching each one.
- After a grant to client 3, clients 0 and 3 request together → client 0 is granted first; client 3 is granted 10 cycles later.
- `rst` asserted during the 4th RUN cycle → all outputs 0 immediately and no `done` pulse. A following request from client 1 with `num` = 0x0000000F completes with `sum` = 15.
- The operand of an in-flight client is changed one cycle after its `gnt` → the result reflects the captured value only.
